pipe_stall_ctrl: RTL and testbench



---
 rtl/pipe_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipe: per-stage enables,
// RAW interlock, memory-wait freeze with timeout, saturating stall counter.
module pipe_stall_ctrl #(
    parameter bit WB_HAZARD   = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wr,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_wr,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_wr,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_en,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             id_valid,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_stall, freeze, hazard;

    function automatic logic hit(
        input logic [4:0] r,
        input logic       exw, input logic [4:0] exr,
        input logic       mw,  input logic [4:0] mr,
        input logic       ww,  input logic [4:0] wr
    );
        return (r != 5'd0) &&
               ((exw && exr == r) ||
                (mw && mr == r) ||
                (WB_HAZARD && ww && wr == r));
    endfunction

    always_comb begin
        mem_stall = mem_req && !mem_ready;
        freeze    = (state_q == ERR) || mem_stall;
        hazard    = (id_uses_rs1 && hit(id_rs1, ex_reg_wr, ex_rd,
                                        mem_reg_wr, mem_rd,
                                        wb_reg_wr, wb_rd)) ||
                    (id_uses_rs2 && hit(id_rs2, ex_reg_wr, ex_rd,
                                        mem_reg_wr, mem_rd,
                                        wb_reg_wr, wb_rd));
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                // a dropped request is treated the same as completion
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_MAX) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
        if ((freeze || hazard) && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        if_en        = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        id_valid     = 1'b0;
        if (reset) begin
            id_ex_bubble = 1'b1;
        end else if (freeze) begin
            id_ex_bubble = 1'b0;
        end else if (hazard) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
        end else begin
            if_en     = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            id_valid  = 1'b1;
        end
    end

    assign mem_err     = mem_err_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, directed corner sequences and
// randomized traffic against a rule-level model, on two parameter sets.
module tb_pipe_stall_ctrl;
    localparam logic [5:0] V_RST = 6'b001000;
    localparam logic [5:0] V_FRZ = 6'b000000;
    localparam logic [5:0] V_HAZ = 6'b011110;
    localparam logic [5:0] V_RUN = 6'b110111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_reg_wr, mem_reg_wr, wb_reg_wr;
    logic       mem_req, mem_ready;

    logic        if_a, idex_a, bub_a, exm_a, mwb_a, idv_a, err_a;
    logic [3:0]  stall_a;
    logic        if_b, idex_b, bub_b, exm_b, mwb_b, idv_b, err_b;
    logic [15:0] stall_b;
    logic [5:0]  vec_a, vec_b;

    assign vec_a = {if_a, idex_a, bub_a, exm_a, mwb_a, idv_a};
    assign vec_b = {if_b, idex_b, bub_b, exm_b, mwb_b, idv_b};

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.WB_HAZARD(1'b1), .MEM_TIMEOUT(8), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
        .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .if_en(if_a), .id_ex_en(idex_a), .id_ex_bubble(bub_a),
        .ex_mem_en(exm_a), .mem_wb_en(mwb_a), .id_valid(idv_a),
        .mem_err(err_a), .stall_count(stall_a)
    );

    pipe_stall_ctrl #(.WB_HAZARD(1'b0), .MEM_TIMEOUT(255), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
        .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .if_en(if_b), .id_ex_en(idex_b), .id_ex_bubble(bub_b),
        .ex_mem_en(exm_b), .mem_wb_en(mwb_b), .id_valid(idv_b),
        .mem_err(err_b), .stall_count(stall_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string      nm;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] exr;
        logic       exw;
        logic [4:0] mr;
        logic       mw;
        logic [4:0] wr;
        logic       ww;
        logic       rq, rdy;
        logic [5:0] ea, eb;
    } vec_t;

    function automatic vec_t mk(
        input string nm,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic u1, input logic u2,
        input logic [4:0] exr, input logic exw,
        input logic [4:0] mr, input logic mw,
        input logic [4:0] wr, input logic ww,
        input logic rq, input logic rdy,
        input logic [5:0] ea, input logic [5:0] eb
    );
        vec_t v;
        v.nm = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exr = exr; v.exw = exw; v.mr = mr; v.mw = mw;
        v.wr = wr; v.ww = ww; v.rq = rq; v.rdy = rdy;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd = 0; ex_reg_wr = 0; mem_rd = 0; mem_reg_wr = 0;
        wb_rd = 0; wb_reg_wr = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_in(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.exr; ex_reg_wr = v.exw;
        mem_rd = v.mr; mem_reg_wr = v.mw;
        wb_rd = v.wr; wb_reg_wr = v.ww;
        mem_req = v.rq; mem_ready = v.rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clr();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rule-level reference: [0] mirrors u_a, [1] mirrors u_b
    bit P_WB  [2] = '{1'b1, 1'b0};
    int P_TO  [2] = '{8, 255};
    int P_MAX [2] = '{15, 65535};
    int m_run [2];
    bit m_err [2];
    int m_stall [2];

    function automatic bit m_hazard(input int k);
        int   dests[$];
        int   srcs[$];
        bit   haz;
        haz = 0;
        if (ex_reg_wr) dests.push_back(int'(ex_rd));
        if (mem_reg_wr) dests.push_back(int'(mem_rd));
        if (P_WB[k] && wb_reg_wr) dests.push_back(int'(wb_rd));
        if (id_uses_rs1) srcs.push_back(int'(id_rs1));
        if (id_uses_rs2) srcs.push_back(int'(id_rs2));
        foreach (srcs[i])
            foreach (dests[j])
                if (srcs[i] != 0 && srcs[i] == dests[j]) haz = 1;
        return haz;
    endfunction

    function automatic bit m_freeze(input int k);
        return m_err[k] || (mem_req && !mem_ready);
    endfunction

    function automatic logic [5:0] m_vec(input int k);
        if (reset) return V_RST;
        if (m_freeze(k)) return V_FRZ;
        if (m_hazard(k)) return V_HAZ;
        return V_RUN;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_err[k] = 0; m_stall[k] = 0;
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            if (m_freeze(k) || m_hazard(k))
                m_stall[k] = (m_stall[k] >= P_MAX[k]) ? P_MAX[k]
                                                      : m_stall[k] + 1;
            // error after more than TO consecutive memory-wait edges
            if (!m_err[k]) begin
                if (mem_req && !mem_ready) begin
                    m_run[k]++;
                    if (m_run[k] > P_TO[k]) m_err[k] = 1;
                end else begin
                    m_run[k] = 0;
                end
            end
        end
    endtask

    vec_t tbl[11];

    initial begin
        clr();
        tbl[0]  = mk("r0_ex",      0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, V_RUN, V_RUN);
        tbl[1]  = mk("rs2_unused", 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, V_RUN, V_RUN);
        tbl[2]  = mk("ex_rs1",     5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, V_HAZ, V_HAZ);
        tbl[3]  = mk("mem_rs2",    0, 9, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0, V_HAZ, V_HAZ);
        tbl[4]  = mk("wb_rs1",     4, 0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 0, V_HAZ, V_RUN);
        tbl[5]  = mk("wr_off",     4, 4, 1, 1, 4, 0, 4, 0, 4, 0, 0, 0, V_RUN, V_RUN);
        tbl[6]  = mk("mem_wait",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, V_FRZ, V_FRZ);
        tbl[7]  = mk("mem_ready",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, V_RUN, V_RUN);
        tbl[8]  = mk("frz_haz",    5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1, 0, V_FRZ, V_FRZ);
        tbl[9]  = mk("rdy_noreq",  3, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, 1, V_RUN, V_RUN);
        tbl[10] = mk("wb_rs2_r31", 0, 31, 0, 1, 0, 0, 0, 0, 31, 1, 0, 0, V_HAZ, V_RUN);

        #3;
        chk("rst_vec", 32'(vec_a), 32'(V_RST));
        chk("rst_cnt", 32'(stall_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = 1'b1;
            set_in(tbl[i]);
            #1;
            reset = 1'b0;
            #1;
            chk({tbl[i].nm, "_a"}, 32'(vec_a), 32'(tbl[i].ea));
            chk({tbl[i].nm, "_b"}, 32'(vec_b), 32'(tbl[i].eb));
        end

        // RAW from EX with the producer draining through MEM and WB
        do_reset();
        id_uses_rs1 = 1; id_rs1 = 5; ex_reg_wr = 1; ex_rd = 5;
        @(negedge clk);
        chk("raw_c1_a", 32'(vec_a), 32'(V_HAZ));
        chk("raw_c1_b", 32'(vec_b), 32'(V_HAZ));
        tick();
        ex_reg_wr = 0; mem_reg_wr = 1; mem_rd = 5;
        @(negedge clk);
        chk("raw_c2_a", 32'(vec_a), 32'(V_HAZ));
        tick();
        mem_reg_wr = 0; wb_reg_wr = 1; wb_rd = 5;
        @(negedge clk);
        chk("raw_c3_a", 32'(vec_a), 32'(V_HAZ));
        chk("raw_c3_b", 32'(vec_b), 32'(V_RUN));
        tick();
        wb_reg_wr = 0;
        @(negedge clk);
        chk("raw_done", 32'(vec_a), 32'(V_RUN));
        chk("raw_cnt_a", 32'(stall_a), 32'd3);
        chk("raw_cnt_b", 32'(stall_b), 32'd2);

        // four cycles of memory wait, then completion
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mw_frz", 32'(vec_a), 32'(V_FRZ));
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("mw_rel", 32'(vec_a), 32'(V_RUN));
        chk("mw_cnt", 32'(stall_a), 32'd4);
        tick();
        mem_req = 0; mem_ready = 0;
        @(negedge clk);
        chk("mw_after", 32'(vec_a), 32'(V_RUN));
        chk("mw_cnt2", 32'(stall_b), 32'd4);
        tick();

        // freeze outranks hazard; hazard resumes after the memory returns
        do_reset();
        ex_reg_wr = 1; ex_rd = 3; id_uses_rs1 = 1; id_rs1 = 3;
        mem_req = 1; mem_ready = 0;
        @(negedge clk);
        chk("fh_frz", 32'(vec_a), 32'(V_FRZ));
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("fh_haz", 32'(vec_a), 32'(V_HAZ));
        tick();
        mem_req = 0;
        @(negedge clk);
        chk("fh_haz2", 32'(vec_a), 32'(V_HAZ));
        chk("fh_cnt", 32'(stall_a), 32'd2);
        tick();

        // timeout on u_a (8 cycles): error on the 9th wait edge, then sticky
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 8) chk("to_before", 32'(err_a), 32'd0);
        end
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_err_b", 32'(err_b), 32'd0);
        mem_ready = 1;
        @(negedge clk);
        chk("to_frz", 32'(vec_a), 32'(V_FRZ));
        chk("to_b_run", 32'(vec_b), 32'(V_RUN));
        tick();
        mem_req = 0;
        @(negedge clk);
        chk("to_sticky", 32'(vec_a), 32'(V_FRZ));
        chk("to_err2", 32'(err_a), 32'd1);
        reset = 1;
        #1;
        chk("to_rst_vec", 32'(vec_a), 32'(V_RST));
        chk("to_rst_err", 32'(err_a), 32'd0);
        chk("to_rst_cnt", 32'(stall_a), 32'd0);
        reset = 0;
        #1;
        chk("to_rst_run", 32'(vec_a), 32'(V_RUN));
        tick();

        // asynchronous reset in the middle of a memory wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        tick();
        tick();
        @(negedge clk);
        #1;
        reset = 1;
        #1;
        chk("arst_vec", 32'(vec_a), 32'(V_RST));
        chk("arst_cnt", 32'(stall_a), 32'd0);
        reset = 0;
        #1;
        chk("arst_frz", 32'(vec_a), 32'(V_FRZ));
        tick();

        // saturation of the 4-bit counter
        do_reset();
        ex_reg_wr = 1; ex_rd = 2; id_uses_rs1 = 1; id_rs1 = 2;
        repeat (20) tick();
        chk("sat_a", 32'(stall_a), 32'd15);
        chk("sat_b", 32'(stall_b), 32'd20);

        // randomized traffic against the model
        do_reset();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit stuck;
            stuck = (cyc % 200) < 40;
            id_rs1 = 5'($urandom_range(3));
            id_rs2 = 5'($urandom_range(3));
            id_uses_rs1 = 1'($urandom_range(1));
            id_uses_rs2 = 1'($urandom_range(1));
            ex_rd = 5'($urandom_range(3));
            mem_rd = 5'($urandom_range(3));
            wb_rd = 5'($urandom_range(3));
            ex_reg_wr = 1'($urandom_range(1));
            mem_reg_wr = 1'($urandom_range(1));
            wb_reg_wr = 1'($urandom_range(1));
            mem_req = stuck ? 1'b1 : 1'($urandom_range(1));
            mem_ready = stuck ? ($urandom_range(19) == 0)
                              : 1'($urandom_range(1));
            reset = ((cyc % 200) == 199) || ($urandom_range(149) == 0);
            @(negedge clk);
            chk("rnd_vec_a", 32'(vec_a), 32'(m_vec(0)));
            chk("rnd_vec_b", 32'(vec_b), 32'(m_vec(1)));
            if (!reset) begin
                chk("rnd_cnt_a", 32'(stall_a), 32'(m_stall[0]));
                chk("rnd_cnt_b", 32'(stall_b), 32'(m_stall[1]));
                chk("rnd_err_a", 32'(err_a), 32'(m_err[0]));
                chk("rnd_err_b", 32'(err_b), 32'(m_err[1]));
            end
            @(posedge clk);
            if (reset) m_reset();
            else m_step();
            #1;
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
